// File: rtl/mem_pkg.sv
// Shared definitions for the parameter memory and its readers: image geometry,
// readback FSM encoding, and the flat-bus byte selector.
package mem_pkg;
  localparam int M = 115;
  localparam int N = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] start_addr;
    logic [7:0] length;
  } req_t;

  // Out-of-range indices read as zero so the slice never leaves the image.
  function automatic logic [N-1:0] byte_sel(input logic [M*N-1:0] img, input logic [7:0] idx);
    if (int'(idx) < M) return img[int'(idx)*N +: N];
    return '0;
  endfunction
endpackage

// File: rtl/memory_readback_if.sv
// Request/stream bundle between a readback client (master) and memory_readback (slave).
interface memory_readback_if;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] length;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output start, start_addr, length, out_ready,
                  input  out_data, out_valid, busy, done, err);
  modport slave  (input  start, start_addr, length, out_ready,
                  output out_data, out_valid, busy, done, err);
endinterface

// File: rtl/mem_byte_mux.sv
// Combinational M:1 byte selector over the flat parameter image.
module mem_byte_mux
  import mem_pkg::*;
(
  input  logic [M*N-1:0] all_data,
  input  logic [7:0]     addr,
  output logic [N-1:0]   byte_out
);
  assign byte_out = byte_sel(all_data, addr);
endmodule

// File: rtl/memory_readback.sv
// Streams a window of the flat parameter image out one byte per valid/ready beat.
// Define MEM_READBACK_CHECKSUM_EN to append a mod-256 checksum beat after the data.
module memory_readback
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [M*N-1:0]     all_data_in,
  memory_readback_if.slave   bus
);
  state_t     state;
  logic [7:0] addr;
  logic [7:0] remain;
  logic [7:0] mux_addr;
  logic [7:0] mux_byte;
  logic [8:0] win_end;
  logic       hs;
  req_t       req;
  logic [7:0] out_data_q;
  logic       out_valid_q, busy_q, done_q, err_q;
`ifdef MEM_READBACK_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign req     = '{start_addr: bus.start_addr, length: bus.length};
  assign hs      = out_valid_q && bus.out_ready;
  assign win_end = {1'b0, req.start_addr} + {1'b0, req.length};
  // In IDLE the mux looks at the requested first byte; while streaming, at the next one.
  assign mux_addr = (state == IDLE) ? req.start_addr : addr + 8'd1;

  mem_byte_mux u_mux (
    .all_data (all_data_in),
    .addr     (mux_addr),
    .byte_out (mux_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      remain      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (req.length == 8'd0) begin
              done_q <= 1'b1;
            end else if (win_end > 9'(M)) begin
              err_q <= 1'b1;
            end else begin
              state       <= STREAM;
              addr        <= req.start_addr;
              remain      <= req.length;
              out_data_q  <= mux_byte;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
`ifdef MEM_READBACK_CHECKSUM_EN
              csum        <= '0;
`endif
            end
          end
        end
        STREAM: begin
          if (hs) begin
`ifdef MEM_READBACK_CHECKSUM_EN
            csum <= csum + out_data_q;
`endif
            if (remain == 8'd1) begin
              remain <= '0;
`ifdef MEM_READBACK_CHECKSUM_EN
              state      <= CSUM;
              out_data_q <= csum + out_data_q;
`else
              state       <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
`endif
            end else begin
              addr       <= addr + 8'd1;
              remain     <= remain - 8'd1;
              out_data_q <= mux_byte;
            end
          end
        end
`ifdef MEM_READBACK_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_memory_readback.sv
// Scoreboard bench for memory_readback: stimulus queues expected beats from an
// array model of the image; a negedge monitor pops and compares each handshake.
module tb_memory_readback;
  import mem_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     img [M];
  logic [M*N-1:0] all_data;
  memory_readback_if bus();

  int   n_checks = 0, n_errors = 0;
  int   n_done = 0, n_err = 0, hs_cnt = 0;
  int   rdy_mode = 0;
  logic [7:0] exp_q [$];
  bit   pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  memory_readback dut (.clk(clk), .reset(reset), .all_data_in(all_data), .bus(bus));

  always #5 clk = ~clk;

  always_comb begin
    all_data = '0;
    for (int j = 0; j < M; j++) all_data[j*N +: N] = img[j];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stall pattern, 3 = never ready
  initial begin : rdy_drv
    int pidx;
    pidx = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: begin bus.out_ready = (pidx < 6) ? pat[pidx] : 1'b1; pidx++; end
        default: bus.out_ready = 1'b0;
      endcase
      if (rdy_mode != 2) pidx = 0;
    end
  end

  initial begin : monitor
    bit stalled, prev_done, prev_err;
    logic [7:0] held, e;
    stalled = 0; prev_done = 0; prev_err = 0; held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0; prev_done = 0; prev_err = 0;
      end else begin
        if (bus.done) begin
          n_done++;
          chk("done_single", prev_done, 0);
          chk("done_idle", {bus.busy, bus.out_valid}, 0);
        end
        if (bus.err) begin
          n_err++;
          chk("err_single", prev_err, 0);
        end
        prev_done = bus.done;
        prev_err  = bus.err;
        if (stalled) chk("hold", {bus.out_valid, bus.out_data}, {1'b1, held});
        if (bus.out_valid && exp_q.size() == 0) chk("extra_beat", bus.out_data, 32'hDEAD);
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", bus.out_data, e);
          hs_cnt++;
        end
        stalled = bus.out_valid && !bus.out_ready;
        held    = bus.out_data;
      end
    end
  end

  task automatic expect_window(input int a, input int l);
    int sum;
    sum = 0;
    for (int k = 0; k < l; k++) begin
      exp_q.push_back(img[a+k]);
      sum += img[a+k];
    end
`ifdef MEM_READBACK_CHECKSUM_EN
    exp_q.push_back(sum[7:0]);
`endif
  endtask

  task automatic pulse_start(input int a, input int l);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = a[7:0]; bus.length = l[7:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int nd);
    int k;
    k = 0;
    while (n_done == nd && k < 2000) begin @(negedge clk); #1; k++; end
    if (k >= 2000) chk("done_timeout", 0, 1);
  endtask

  task automatic run_txn(input int a, input int l);
    int nd, ne, nb;
    bit legal, bad;
    legal = (l != 0) && (a + l <= M);
    bad   = (l != 0) && !legal;
    nd = n_done; ne = n_err; nb = 0;
    if (legal) begin
      expect_window(a, l);
      nb = l;
`ifdef MEM_READBACK_CHECKSUM_EN
      nb++;
`endif
    end
    pulse_start(a, l);
    chk("first_valid", bus.out_valid, legal);
    chk("busy_on", bus.busy, legal);
    chk("err_next", bus.err, bad);
    chk("len0_done", bus.done, l == 0);
    if (legal) begin
      if (rdy_mode == 0) begin
        repeat (nb) @(posedge clk);
        #1 chk("done_latency", bus.done, 1);
      end else begin
        wait_done(nd);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    chk("done_count", n_done, nd + ((legal || l == 0) ? 1 : 0));
    chk("err_count", n_err, ne + (bad ? 1 : 0));
    chk("queue_empty", exp_q.size(), 0);
    chk("end_idle", {bus.out_valid, bus.busy}, 0);
  endtask

  initial begin : stim
    int nd, ne, base, k;
    for (int j = 0; j < M; j++) img[j] = 8'(j + 1);
    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.out_data, bus.out_valid, bus.busy, bus.done, bus.err}, 0);
    reset = 1'b0;

    rdy_mode = 0; run_txn(4, 3);
    rdy_mode = 2; run_txn(4, 3);
    rdy_mode = 0; run_txn(110, 6);
    run_txn(110, 5);
    run_txn(0, 0);
    run_txn(0, 115);

    // reset after the fourth handshake of a ten-byte stream
    rdy_mode = 0;
    nd = n_done;
    expect_window(20, 10);
    base = hs_cnt;
    pulse_start(20, 10);
    k = 0;
    while (hs_cnt < base + 4 && k < 100) begin @(negedge clk); #1; k++; end
    rdy_mode = 3;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
`ifdef MEM_READBACK_CHECKSUM_EN
    chk("rst_mid_left", exp_q.size(), 7);
`else
    chk("rst_mid_left", exp_q.size(), 6);
`endif
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("rst_no_done", n_done, nd);
    rdy_mode = 0;
    run_txn(50, 4);

    // starts while busy must be ignored
    rdy_mode = 1;
    nd = n_done; ne = n_err;
    expect_window(30, 10);
    pulse_start(30, 10);
    repeat (2) @(posedge clk);
    pulse_start(0, 3);
    pulse_start(110, 20);
    wait_done(nd);
    repeat (2) @(negedge clk);
    #1;
    chk("busy_start_done", n_done, nd + 1);
    chk("busy_start_err", n_err, ne);
    chk("busy_start_q", exp_q.size(), 0);

    // randomized windows over a fresh random image each time
    for (int t = 0; t < 30; t++) begin
      for (int j = 0; j < M; j++) img[j] = 8'($urandom);
      rdy_mode = $urandom_range(0, 2);
      run_txn($urandom_range(0, 125), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/memory_readback.md
Name: memory_readback

Overview:
- Reader end of the byte-addressable parameter memory: the memory is written byte-by-byte and exposes its whole contents as a flat bus.
- This block walks a requested address window of that flat image and streams the bytes out one per handshake on a valid/ready byte interface.
- It feeds the SPI/UART readback path so the host can verify what was loaded.

Parameters:
- M, 115, number of bytes in the memory image.
- N, 8, byte width in bits; fixed at 8, and other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- all_data_in  input  M*N  flat memory image; byte j occupies bits [j*8 +: 8].
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- start_addr  input  8  first byte index of the window.
- length  input  8  number of bytes to stream.
- out_ready  input  1  downstream accepts the byte this cycle.
- out_data  output  8  current byte.
- out_valid  output  1  out_data holds a valid byte.
- busy  output  1  high from the cycle after an accepted start until the final beat handshakes.
- done  output  1  one-cycle pulse the cycle after the final beat handshakes.
- err  output  1  one-cycle pulse when a start request has an illegal window.

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - out_data=0, out_valid=0, busy=0, done=0, err=0; FSM goes to IDLE; address and remaining counters are 0.
  - Reset mid-stream aborts immediately: no done pulse, and the stream is not resumed.
- FSM states: IDLE, STREAM, CSUM (CSUM exists only with the optional feature).
- IDLE:
  - On start with length==0: done pulses next cycle; no beats are produced; stay in IDLE.
  - On start with start_addr+length > M: err pulses next cycle; no beats are produced; stay in IDLE. The sum is computed 9 bits wide, so there is no wrap.
  - On a legal start: next cycle out_valid=1, out_data=byte[start_addr], busy=1, go to STREAM. Latency from start to first valid is 1 cycle.
- STREAM:
  - Handshake is out_valid && out_ready in the same cycle.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - On a handshake with beats remaining, the next cycle presents byte[addr+1] with out_valid still 1. Back-to-back beats give one byte per cycle.
  - On the handshake of the last data byte, go to IDLE (or to CSUM if enabled). out_valid=0 and busy=0 next cycle, and done pulses that same cycle.
- Data sampling:
  - Each byte is taken from all_data_in at the cycle it is loaded into out_data.
  - Later changes to the image do not affect a byte already presented.
- start while busy is ignored: no err and no restart.
- Address counter is 8 bits; legal windows never exceed M-1, so no wrap-around occurs.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: MEM_READBACK_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit checksum register clears on an accepted start and accumulates (sum mod 256) each handshaken data byte.
  - After the last data handshake the FSM enters CSUM and presents out_data=checksum with out_valid=1, obeying the same hold rule.
  - done pulses the cycle after the checksum handshake.
  - For length==0 no checksum beat is sent.
- Without the macro: no checksum register and no CSUM state; the stream ends after the last data byte.

Decomposition:
- Shared package mem_pkg holds:
  - M and N constants, shared with the memory block.
  - The FSM state encoding: IDLE=2'd0, STREAM=2'd1, CSUM=2'd2.
  - The byte-select helper function for the flat-bus slice.
- One natural sub-module: mem_byte_mux. It is a combinational M:1 byte selector from the flat bus, indexed by the address counter, and can be reused by other readers of the image.

Test Plan:
- Image byte j = j+1. Start, start_addr=4, length=3, out_ready=1 constant -> bytes 5,6,7 on three consecutive cycles starting 1 cycle after start; done the cycle after the byte 7 handshake. With CHECKSUM_EN, a fourth beat 0x12 precedes done.
- Same window with out_ready toggling 0,1,0,0,1,1 -> out_data held stable during every stall; exactly 3 data beats in order; no duplicates and no drops.
- start_addr=110, length=6 (110+6 > 115) -> err pulse next cycle; out_valid stays 0; busy stays 0. Then start_addr=110, length=5 -> bytes 111..115 stream normally.
- length=0 -> done pulse next cycle; out_valid never asserts; no checksum beat.
- Start a 10-byte stream, assert reset after the 4th handshake -> next cycle out_valid=0, busy=0, and no done pulse. A new start then streams correctly from its own start_addr.
- Pulse start again at mid-stream -> ignored; the original stream completes unchanged with a single done pulse.
